// File: rtl/tick_gen_pkg.sv
// Shared defaults and helpers for the multi-channel tick generator.
package tick_gen_pkg;

  localparam int NUM_CH_DEF  = 4;
  localparam int DIV_W_DEF   = 27;
  localparam int DEF_DIV_DEF = 4;
  localparam int SCAN_W_DEF  = 2;

  // Channel-index width; a single channel still needs a 1-bit select port.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_chan.sv
// One divider channel: counter, active/shadow divisor, tick pulse and square wave.
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             wrap,
  output logic             tick,
  output logic             sq
);

  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] RST_D = DIV_W'(DEF_DIV);

  logic [DIV_W-1:0] act;
  logic [DIV_W-1:0] shd;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] last;

  // A zero divisor behaves as one, so the terminal count is 0 in both cases.
  assign last = (act == '0) ? '0 : act - ONE;
  assign wrap = en && (cnt == last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      act  <= RST_D;
      shd  <= RST_D;
      tick <= 1'b0;
      sq   <= 1'b0;
    end else begin
      tick <= wrap;
      if (wr) shd <= wr_div;
      if (wrap) begin
        cnt <= '0;
        sq  <= ~sq;
        // A write landing on the wrap edge takes effect immediately.
        act <= wr ? wr_div : shd;
      end else if (en) begin
        cnt <= cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/tick_gen.sv
// Multi-channel clock-enable generator with shadowed divisors and a scan counter.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF,
  parameter int SCAN_W  = SCAN_W_DEF,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_ack,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic [SCAN_W-1:0] scan
);

  logic              wr_ok;
  logic [NUM_CH-1:0] wrap;
  logic              unused_wrap;

  // Indices beyond the populated channels are dropped without acknowledge.
  assign wr_ok       = cfg_we && (32'(cfg_ch) < NUM_CH);
  assign unused_wrap = ^wrap;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_i;
    assign wr_i = wr_ok && (cfg_ch == CH_W'(i));

    tick_chan #(
      .DIV_W  (DIV_W),
      .DEF_DIV(DEF_DIV)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .wr    (wr_i),
      .wr_div(cfg_div),
      .wrap  (wrap[i]),
      .tick  (tick[i]),
      .sq    (sq[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_ack <= 1'b0;
      scan    <= '0;
    end else begin
      cfg_ack <= wr_ok;
      if (wrap[0]) scan <= scan + SCAN_W'(1);
    end
  end

endmodule
